// File: rtl/sram_master.sv
// sram_master: request/response initiator for a single-port SRAM macro.
// After reset it zero-fills the array (when p_init=1). It then maps a valid/ready
// request stream onto the macro's active-low strobes. Read data returns in order
// through a 2-entry fall-through FIFO.
// Ports:
//   CLK, RSTN                          clock, synchronous active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                 request stream (write or read)
//   rsp_valid/rsp_ready/rsp_rdata      read response stream, in request order
//   init_done                          high once the fill has finished
//   sram_cen/sram_wen/sram_a/sram_d    macro control/address/data pins
//   sram_q                             macro read data (one cycle after access)
module sram_master #(
    parameter int unsigned p_addr_bit = 5,
    parameter int unsigned p_data_bit = 32,
    parameter bit          p_init     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [p_addr_bit-1:0] req_addr,
    input  logic [p_data_bit-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [p_data_bit-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [p_addr_bit-1:0] sram_a,
    output logic [p_data_bit-1:0] sram_d,
    input  logic [p_data_bit-1:0] sram_q
);

    localparam logic [p_addr_bit-1:0] last_addr = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t reset_state = p_init ? INIT : RUN;

    state_t                  state;
    state_t                  state_next;
    logic [p_addr_bit-1:0]   init_cnt;
    logic                    rd_inflight;
    logic [p_data_bit-1:0]   fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_count;
    logic [1:0]              credit_used;
    logic                    issue;
    logic                    push;
    logic                    pop;

    assign rsp_valid   = (fifo_count != 2'd0);
    assign rsp_rdata   = fifo_mem[rd_ptr];
    assign pop         = rsp_valid & rsp_ready;
    assign push        = rd_inflight;
    // Buffered responses plus the read whose data lands next edge.
    assign credit_used = fifo_count + {1'b0, rd_inflight};
    assign issue       = req_valid & req_ready;
    // Held low while reset is asserted so the reset value is seen even when p_init=0.
    assign init_done   = RSTN && (state == RUN);

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= reset_state;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the fill ends after the write to the last address
    always_comb begin
        state_next = state;
        if (state == INIT && init_cnt == last_addr) begin
            state_next = RUN;
        end
    end

    // Output logic: fill writes in INIT, request-driven pins in RUN
    always_comb begin
        req_ready = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        // The macro is kept idle while reset is asserted.
        if (RSTN) begin
            if (state == INIT) begin
                sram_cen = 1'b0;
                sram_wen = 1'b0;
                sram_a   = init_cnt;
            end else begin
                // A same-cycle pop frees a slot for a new request.
                req_ready = (credit_used < 2'd2) || pop;
                if (req_valid && req_ready) begin
                    sram_cen = 1'b0;
                    sram_wen = ~req_we;
                    sram_a   = req_addr;
                    sram_d   = req_wdata;
                end
            end
        end
    end

    // Fill counter, read tracking and response FIFO
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            init_cnt    <= '0;
            rd_inflight <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (state == INIT) begin
                init_cnt <= p_addr_bit'(init_cnt + 1'b1);
            end
            rd_inflight <= issue & ~req_we;
            if (push) begin
                fifo_mem[wr_ptr] <= sram_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= 2'(fifo_count + 2'd1);
                2'b01:   fifo_count <= 2'(fifo_count - 2'd1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The credit rule must keep a push from landing in a full FIFO.
    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && fifo_count == 2'd2 && !pop));

endmodule

// File: tb/tb_sram_master.sv
// tb_sram_master: bench for sram_master with a behavioural SRAM macro. A shadow-memory
// reference model predicts the handshake, the pin activity and the response data on
// every cycle. Directed scenarios pin the model with literal values, and a randomized
// phase then exercises mixed traffic.
`timescale 1ns/1ps
module tb_sram_master;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;

    always #5 CLK = ~CLK;

    sram_master #(.p_addr_bit(AW), .p_data_bit(DW), .p_init(1'b1)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Single-port macro: write or read at the edge, Q valid the following cycle.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_wen) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    bit            model_live = 1'b0;
    int            fill_left  = 0;
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] rsp_q [$];
    bit            pend = 1'b0;
    logic [DW-1:0] pend_data;
    bit            exp_ready;
    bit            popped;
    logic [DW-1:0] pop_log [$];
    int            pop_cyc [$];

    // Compare against the model mid-cycle, then advance it past the coming edge.
    always @(negedge CLK) begin
        exp_ready = 1'b0;
        if (model_live) begin
            if (!RSTN) begin
                check("rst_req_ready", req_ready, 0);
                check("rst_sram_cen", sram_cen, 1);
                check("rst_init_done", init_done, 0);
                check("rst_rsp_valid", rsp_valid, rsp_q.size() != 0);
            end else if (fill_left > 0) begin
                check("fill_req_ready", req_ready, 0);
                check("fill_init_done", init_done, 0);
                check("fill_rsp_valid", rsp_valid, 0);
                check("fill_cen", sram_cen, 0);
                check("fill_wen", sram_wen, 0);
                check("fill_addr", sram_a, AW'(DEPTH - fill_left));
                check("fill_data", sram_d, 0);
            end else begin
                exp_ready = ((rsp_q.size() + (pend ? 1 : 0)) < 2) ||
                            (rsp_q.size() != 0 && rsp_ready);
                check("run_init_done", init_done, 1);
                check("run_req_ready", req_ready, exp_ready);
                check("run_rsp_valid", rsp_valid, rsp_q.size() != 0);
                if (rsp_q.size() != 0) check("run_rsp_rdata", rsp_rdata, rsp_q[0]);
                if (req_valid && exp_ready) begin
                    check("acc_cen", sram_cen, 0);
                    check("acc_wen", sram_wen, !req_we);
                    check("acc_addr", sram_a, req_addr);
                    if (req_we) check("acc_data", sram_d, req_wdata);
                end else begin
                    check("idle_cen", sram_cen, 1);
                end
            end
        end
        if (!RSTN) begin
            model_live = 1'b1;
            fill_left  = DEPTH;
            rsp_q.delete();
            pend = 1'b0;
        end else if (model_live) begin
            if (fill_left > 0) begin
                shadow[DEPTH - fill_left] = '0;
                fill_left--;
            end else begin
                popped = (rsp_q.size() != 0) && rsp_ready;
                if (popped) begin
                    pop_log.push_back(rsp_rdata);
                    pop_cyc.push_back(cyc);
                    void'(rsp_q.pop_front());
                end
                if (pend) begin
                    rsp_q.push_back(pend_data);
                    pend = 1'b0;
                end
                if (req_valid && exp_ready) begin
                    if (req_we) shadow[req_addr] = req_wdata;
                    else begin
                        pend      = 1'b1;
                        pend_data = shadow[req_addr];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Present one request, hold until accepted (bounded), return cycles waited.
    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int n);
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #0.1;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_wait_bound", n < 100, 1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hits;
        RSTN      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
        repeat (3) tick();

        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_init_done", init_done, 0);
        check("reset_sram_cen", sram_cen, 1);

        // Fill length
        RSTN = 1'b1;
        wait_ready(n);
        check("fill_cycles", n, 32);
        check("fill_done", init_done, 1);

        // Write then read back-to-back
        rsp_ready = 1'b1;
        do_req(1'b1, 5'd5, 32'hDEADBEEF, n);
        do_req(1'b0, 5'd5, '0, n);
        check("b2b_read_wait", n, 0);
        check("rd_lat_early", rsp_valid, 0);
        tick();
        check("rd_lat_valid", rsp_valid, 1);
        check("rd_data_5", rsp_rdata, 32'hDEADBEEF);
        tick();

        // Untouched address reads the fill value
        do_req(1'b0, 5'd31, '0, n);
        tick();
        check("rd31_valid", rsp_valid, 1);
        check("rd31_data", rsp_rdata, 0);
        tick();

        // Backpressure
        rsp_ready = 1'b0;
        do_req(1'b1, 5'd1, 32'h11, n);
        do_req(1'b1, 5'd2, 32'h22, n);
        pop_log.delete();
        do_req(1'b0, 5'd1, '0, n);
        do_req(1'b0, 5'd2, '0, n);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd1;
        #1;
        check("bp_ready_low", req_ready, 0);
        tick();
        tick();
        check("bp_ready_still_low", req_ready, 0);
        check("bp_fifo_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        #1;
        check("bp_pop_credit", req_ready, 1);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("bp_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            check("bp_rsp0", pop_log[0], 32'h11);
            check("bp_rsp1", pop_log[1], 32'h22);
            check("bp_rsp2", pop_log[2], 32'h11);
        end

        // Streaming reads
        pop_log.delete();
        pop_cyc.delete();
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i);
            #1;
            if (req_ready) hits++;
            tick();
        end
        req_valid = 1'b0;
        repeat (4) tick();
        check("stream_ready", hits, 32);
        check("stream_count", pop_log.size(), 32);
        if (pop_log.size() == 32) begin
            check("stream_back2back", pop_cyc[31] - pop_cyc[0], 31);
            check("stream_rsp0", pop_log[0], 0);
            check("stream_rsp1", pop_log[1], 32'h11);
            check("stream_rsp2", pop_log[2], 32'h22);
            check("stream_rsp5", pop_log[5], 32'hDEADBEEF);
        end

        // Randomized mixed traffic
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) != 0;
            req_addr  = AW'($urandom_range(0, DEPTH - 1));
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) tick();

        // Reset with the FIFO full
        rsp_ready = 1'b0;
        do_req(1'b0, 5'd3, '0, n);
        do_req(1'b0, 5'd4, '0, n);
        tick();
        tick();
        check("pre_rst_valid", rsp_valid, 1);
        check("pre_rst_ready", req_ready, 0);
        RSTN = 1'b0;
        tick();
        check("post_rst_valid", rsp_valid, 0);
        check("post_rst_ready", req_ready, 0);
        check("post_rst_cen", sram_cen, 1);
        RSTN = 1'b1;
        #1;
        check("refill_cen", sram_cen, 0);
        check("refill_addr0", sram_a, 0);
        wait_ready(n);
        check("refill_cycles", n, 32);
        rsp_ready = 1'b1;
        do_req(1'b0, 5'd4, '0, n);
        tick();
        check("refill_rd_valid", rsp_valid, 1);
        check("refill_rd_data", rsp_rdata, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
